// File: rtl/read_buffer.sv
// Line-to-element read buffer: latches one FULL_WIDTH read line and emits its lanes
// from base up to min(bounds, N) one element per cycle, MSB lane first.
module read_buffer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rready,
    input  logic [FULL_WIDTH-1:0] rdata,
    input  logic                  odata_req,
    input  logic [7:0]            base,
    input  logic [7:0]            bounds,
    output logic                  oready,
    output logic [WIDTH-1:0]      odata
);

    localparam int N  = FULL_WIDTH / WIDTH;
    localparam int IW = $clog2(N) + 1;

    // Saturate an 8-bit lane index to N so idx/end_l never exceed the lane count.
    function automatic logic [IW-1:0] clamp_n(input logic [7:0] v);
        if (v > 8'(N)) return IW'(N);
        return v[IW-1:0];
    endfunction

    logic [FULL_WIDTH-1:0] line;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         end_l;
    logic [WIDTH-1:0]      lane_sel;
    logic                  emit;

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) lane_sel = line[FULL_WIDTH-1-i*WIDTH -: WIDTH];
        end
    end

    assign emit = !rready && odata_req && (idx < end_l);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line   <= '0;
            idx    <= '0;
            end_l  <= '0;
            oready <= 1'b0;
            odata  <= '0;
        end else if (rready) begin
            // base is clamped too, so an out-of-range base still yields an empty line
            line   <= rdata;
            idx    <= clamp_n(base);
            end_l  <= clamp_n(bounds);
            oready <= 1'b0;
        end else if (emit) begin
            odata  <= lane_sel;
            oready <= 1'b1;
            idx    <= idx + 1'b1;
        end else begin
            oready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_read_buffer.sv
// Directed bench for read_buffer: WIDTH=64 (N=8) and WIDTH=128 (N=4) instances share stimulus.
module tb_read_buffer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         rready;
    logic [511:0] rdata;
    logic         odata_req;
    logic [7:0]   base;
    logic [7:0]   bounds;
    logic         oready64;
    logic [63:0]  odata64;
    logic         oready128;
    logic [127:0] odata128;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] LA = 128'h000A_0000_0000_0000_0000_0000_0000_00A1;
    localparam logic [127:0] LB = 128'h000B_0000_0000_0000_0000_0000_0000_00B2;
    localparam logic [127:0] LC = 128'h000C_0000_0000_0000_0000_0000_0000_00C3;
    localparam logic [127:0] LD = 128'h000D_0000_0000_0000_0000_0000_0000_00D4;

    read_buffer #(.FULL_WIDTH(512), .WIDTH(64)) dut64 (
        .clock(clock), .reset_n(reset_n), .rready(rready), .rdata(rdata),
        .odata_req(odata_req), .base(base), .bounds(bounds),
        .oready(oready64), .odata(odata64)
    );

    read_buffer #(.FULL_WIDTH(512), .WIDTH(128)) dut128 (
        .clock(clock), .reset_n(reset_n), .rready(rready), .rdata(rdata),
        .odata_req(odata_req), .base(base), .bounds(bounds),
        .oready(oready128), .odata(odata128)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // 64-bit lanes with lane i = off + i, lane 0 in the top slice
    function automatic logic [511:0] mk64(input int off);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[511-i*64 -: 64] = 64'(off + i);
        return r;
    endfunction

    task automatic load(input logic [511:0] d, input logic [7:0] b, input logic [7:0] e);
        rready = 1'b1;
        rdata  = d;
        base   = b;
        bounds = e;
        step();
        rready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        rready    = 1'b0;
        rdata     = '0;
        odata_req = 1'b0;
        base      = '0;
        bounds    = '0;
        #3;
        chk("reset_oready64", oready64, 0);
        chk("reset_odata64", odata64, 0);
        chk("reset_oready128", oready128, 0);
        #4 reset_n = 1'b1;
        step();
        chk("idle_oready", oready64, 0);

        // full line, lanes 1..8
        odata_req = 1'b1;
        load(mk64(1), 8'd0, 8'd8);
        chk("full_load_oready", oready64, 0);
        chk("full_load_odata_hold", odata64, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("full_oready_%0d", k), oready64, 1);
            chk($sformatf("full_odata_%0d", k), odata64, 64'(k));
        end
        step();
        chk("full_end_oready", oready64, 0);
        chk("full_end_odata_hold", odata64, 8);

        // offset line: base=3 -> 4..8
        load(mk64(1), 8'd3, 8'd8);
        for (int k = 4; k <= 8; k++) begin
            step();
            chk($sformatf("off_oready_%0d", k), oready64, 1);
            chk($sformatf("off_odata_%0d", k), odata64, 64'(k));
        end
        step();
        chk("off_end_oready", oready64, 0);

        // partial line: bounds=2 -> exactly 1,2
        load(mk64(1), 8'd0, 8'd2);
        step();
        chk("part_odata_1", odata64, 1);
        step();
        chk("part_odata_2", odata64, 2);
        chk("part_oready_2", oready64, 1);
        step();
        chk("part_end_oready", oready64, 0);

        // WIDTH=128, bounds=9 clamped to 4
        load({LA, LB, LC, LD}, 8'd0, 8'd9);
        chk("w128_load_oready", oready128, 0);
        step();
        chk("w128_A", odata128, LA);
        step();
        chk("w128_B", odata128, LB);
        step();
        chk("w128_C", odata128, LC);
        step();
        chk("w128_D", odata128, LD);
        chk("w128_D_oready", oready128, 1);
        step();
        chk("w128_no_fifth", oready128, 0);
        step();
        chk("w128_no_fifth2", oready128, 0);

        // backpressure after the 2nd element
        load(mk64(1), 8'd0, 8'd8);
        step();
        step();
        chk("bp_odata_2", odata64, 2);
        odata_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_stall_%0d", k), oready64, 0);
        end
        odata_req = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            step();
            chk($sformatf("bp_oready_%0d", k), oready64, 1);
            chk($sformatf("bp_odata_%0d", k), odata64, 64'(k));
        end
        step();
        chk("bp_end_oready", oready64, 0);

        // reload after 2 elements of X with Y (lanes 0x11..), bounds=1
        load(mk64(1), 8'd0, 8'd8);
        step();
        step();
        load(mk64(17), 8'd0, 8'd1);
        chk("reload_load_oready", oready64, 0);
        chk("reload_load_odata_hold", odata64, 2);
        step();
        chk("reload_y0_oready", oready64, 1);
        chk("reload_y0", odata64, 17);
        step();
        chk("reload_no_more", oready64, 0);
        step();
        chk("reload_no_more2", oready64, 0);

        // empty load: base == bounds
        load(mk64(1), 8'd5, 8'd5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("empty_%0d", k), oready64, 0);
        end

        // async reset mid-drain
        load(mk64(1), 8'd0, 8'd8);
        step();
        step();
        chk("rst_pre_odata", odata64, 2);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_oready", oready64, 0);
        chk("rst_mid_odata", odata64, 0);
        chk("rst_mid_oready128", oready128, 0);
        chk("rst_mid_odata128", odata128, 0);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rst_after_%0d", k), oready64, 0);
        end
        chk("rst_after_odata", odata64, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
